// File: rtl/chunked_serial_adder_if.sv
// Handshake/operand bundle for chunked_serial_adder: operands and mode on the input
// side, sum/carry/overflow on the output side.
interface chunked_serial_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             co;
   logic             ovf;

   modport master (
      output in_valid, x, y, ci, sub, out_ready,
      input  in_ready, out_valid, s, co, ovf
   );

   modport slave (
      input  in_valid, x, y, ci, sub, out_ready,
      output in_ready, out_valid, s, co, ovf
   );
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock, carry held between cycles.
// Optional macro CHUNKED_SERIAL_ADDER_SAT_EN saturates s on signed overflow in DONE.
module chunked_serial_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 2
) (
   input logic                   clk,
   input logic                   rst_n,
   chunked_serial_adder_if.slave bus
);
   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0]    LAST = CW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, res_reg;
   logic             carry, c_msb;
   logic [CW-1:0]    cnt;
   logic             accept, last_chunk;
   int unsigned      idx;
   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic [CHUNK:0]   chunk_sum;
   logic             msb_carry;
   logic             ovf_int;

   assign accept     = (state == IDLE) && bus.in_valid;
   assign last_chunk = (cnt == LAST);

   // Shift-based chunk selection keeps the slice mux width-clean for any CHUNK.
   always_comb begin
      idx       = 32'(cnt) * CHUNK;
      a_chunk   = CHUNK'(a_reg >> idx);
      b_chunk   = CHUNK'(b_reg >> idx);
      chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
      msb_carry = chunk_sum[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_next = RUN;
         end
         RUN: begin
            if (last_chunk) state_next = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         carry   <= 1'b0;
         c_msb   <= 1'b0;
         cnt     <= '0;
      end else if (accept) begin
         a_reg <= bus.x;
         b_reg <= bus.sub ? ~bus.y : bus.y;
         carry <= bus.sub ? 1'b1 : bus.ci;
         cnt   <= '0;
      end else if (state == RUN) begin
         res_reg <= (res_reg & ~(MASK << idx)) | (WIDTH'(chunk_sum[CHUNK-1:0]) << idx);
         carry   <= chunk_sum[CHUNK];
         if (last_chunk) begin
            c_msb <= msb_carry;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign ovf_int = c_msb ^ carry;
   assign bus.co  = carry;
   assign bus.ovf = ovf_int;

`ifdef CHUNKED_SERIAL_ADDER_SAT_EN
   // On overflow both operands share a sign, so A's MSB gives the true result sign.
   logic [WIDTH-1:0] sat_val;
   assign sat_val = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   assign bus.s   = ((state == DONE) && ovf_int) ? sat_val : res_reg;
`else
   assign bus.s = res_reg;
`endif
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed and model-checked bench for chunked_serial_adder (8/2, 16/1 and 16/16 builds).
module tb_chunked_serial_adder;
`ifdef CHUNKED_SERIAL_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   chunked_serial_adder_if #(.WIDTH(8))  bus8 ();
   chunked_serial_adder_if #(.WIDTH(16)) bus_c1 ();
   chunked_serial_adder_if #(.WIDTH(16)) bus_c16 ();

   chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
   );
   chunked_serial_adder #(.WIDTH(16), .CHUNK(1)) dut_c1 (
      .clk(clk), .rst_n(rst_n), .bus(bus_c1.slave)
   );
   chunked_serial_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (
      .clk(clk), .rst_n(rst_n), .bus(bus_c16.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic sb, output int lat);
      @(negedge clk);
      bus8.x = a; bus8.y = b; bus8.ci = c; bus8.sub = sb; bus8.in_valid = 1'b1;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic ack8;
      bus8.out_ready = 1'b1;
      @(negedge clk);
      bus8.out_ready = 1'b0;
   endtask

   task automatic res8(input string tag, input int lat, input logic [7:0] es,
                       input logic eco, input logic eovf);
      chk({tag, "_lat"}, 32'(lat), 32'd4);
      chk({tag, "_s"},   32'(bus8.s), 32'(es));
      chk({tag, "_co"},  32'(bus8.co), 32'(eco));
      chk({tag, "_ovf"}, 32'(bus8.ovf), 32'(eovf));
   endtask

   initial begin
      int          lat, n, lat1, lat16;
      logic [15:0] xa, yb, es, s1, s16;
      logic        c, sb, eco, eovf, d1, d16, co1, co16, ovf1, ovf16;
      logic [16:0] full;

      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
      bus8.x = '0; bus8.y = '0; bus8.ci = 1'b0; bus8.sub = 1'b0;
      bus_c1.in_valid = 1'b0; bus_c1.out_ready = 1'b0;
      bus_c1.x = '0; bus_c1.y = '0; bus_c1.ci = 1'b0; bus_c1.sub = 1'b0;
      bus_c16.in_valid = 1'b0; bus_c16.out_ready = 1'b0;
      bus_c16.x = '0; bus_c16.y = '0; bus_c16.ci = 1'b0; bus_c16.sub = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_in_ready",  32'(bus8.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("rst_s",         32'(bus8.s), 32'd0);
      chk("rst_co",        32'(bus8.co), 32'd0);
      chk("rst_ovf",       32'(bus8.ovf), 32'd0);
      rst_n = 1'b1;

      op8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
      res8("add_7f_01", lat, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1);
      ack8();
      chk("add_7f_01_in_ready", 32'(bus8.in_ready), 32'd1);

      bus8.out_ready = 1'b1;
      op8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
      res8("add_ff_01_rdyhi", lat, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      bus8.out_ready = 1'b0;
      chk("add_ff_01_in_ready", 32'(bus8.in_ready), 32'd1);

      op8(8'hFF, 8'h00, 1'b1, 1'b0, lat);
      res8("add_ff_00_ci", lat, 8'h00, 1'b1, 1'b0);
      ack8();

      op8(8'h05, 8'h07, 1'b0, 1'b1, lat);
      res8("sub_05_07", lat, 8'hFE, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus8.in_valid = i[0];
         bus8.x = 8'hAA; bus8.y = 8'h11; bus8.sub = 1'b0;
         @(negedge clk);
         chk("bp_in_ready", 32'(bus8.in_ready), 32'd0);
         chk("bp_hold", {22'd0, bus8.s, bus8.co, bus8.ovf}, {22'd0, 8'hFE, 1'b0, 1'b0});
      end
      bus8.in_valid = 1'b0;
      chk("bp_out_valid", 32'(bus8.out_valid), 32'd1);
      bus8.out_ready = 1'b1;
      chk("bp_in_ready_pre", 32'(bus8.in_ready), 32'd0);
      @(negedge clk);
      bus8.out_ready = 1'b0;
      chk("bp_in_ready_post", 32'(bus8.in_ready), 32'd1);
      chk("bp_out_valid_post", 32'(bus8.out_valid), 32'd0);

      op8(8'h80, 8'h01, 1'b0, 1'b1, lat);
      res8("sub_80_01", lat, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1);
      ack8();

      op8(8'h10, 8'h10, 1'b1, 1'b1, lat);
      res8("sub_ci_ignored", lat, 8'h00, 1'b1, 1'b0);
      ack8();

      @(negedge clk);
      bus8.x = 8'h55; bus8.y = 8'h33; bus8.ci = 1'b1; bus8.sub = 1'b0; bus8.in_valid = 1'b1;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrun_busy", 32'(bus8.out_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready",  32'(bus8.in_ready), 32'd1);
      chk("midrst_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("midrst_s",         32'(bus8.s), 32'd0);
      chk("midrst_co",        32'(bus8.co), 32'd0);
      chk("midrst_ovf",       32'(bus8.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst_no_spurious", 32'(bus8.out_valid), 32'd0);
      op8(8'h10, 8'h20, 1'b0, 1'b0, lat);
      res8("after_rst_10_20", lat, 8'h30, 1'b0, 1'b0);
      ack8();

      // Reference sweep: both 16-bit builds receive identical operands each op.
      for (int i = 0; i < 40; i++) begin
         xa = 16'($urandom); yb = 16'($urandom);
         c = 1'($urandom); sb = 1'($urandom);
         if (i == 0) begin xa = 16'h7FFF; yb = 16'h0001; c = 1'b0; sb = 1'b0; end
         if (i == 1) begin xa = 16'h8000; yb = 16'h0001; c = 1'b0; sb = 1'b1; end
         if (i == 2) begin xa = 16'hFFFF; yb = 16'h0000; c = 1'b1; sb = 1'b0; end
         full = sb ? ({1'b0, xa} + {1'b0, ~yb} + 17'd1) : ({1'b0, xa} + {1'b0, yb} + {16'd0, c});
         eco  = full[16];
         es   = full[15:0];
         eovf = sb ? ((xa[15] != yb[15]) && (es[15] != xa[15]))
                   : ((xa[15] == yb[15]) && (es[15] != xa[15]));
         if (SAT && eovf) es = xa[15] ? 16'h8000 : 16'h7FFF;

         @(negedge clk);
         bus_c1.x = xa; bus_c1.y = yb; bus_c1.ci = c; bus_c1.sub = sb; bus_c1.in_valid = 1'b1;
         bus_c16.x = xa; bus_c16.y = yb; bus_c16.ci = c; bus_c16.sub = sb; bus_c16.in_valid = 1'b1;
         @(negedge clk);
         bus_c1.in_valid = 1'b0;
         bus_c16.in_valid = 1'b0;

         n = 0; d1 = 1'b0; d16 = 1'b0; lat1 = -1; lat16 = -1;
         s1 = '0; co1 = 1'b0; ovf1 = 1'b0; s16 = '0; co16 = 1'b0; ovf16 = 1'b0;
         while (n < 40) begin
            if (!d1 && bus_c1.out_valid === 1'b1) begin
               d1 = 1'b1; lat1 = n; s1 = bus_c1.s; co1 = bus_c1.co; ovf1 = bus_c1.ovf;
            end
            if (!d16 && bus_c16.out_valid === 1'b1) begin
               d16 = 1'b1; lat16 = n; s16 = bus_c16.s; co16 = bus_c16.co; ovf16 = bus_c16.ovf;
            end
            if (d1 && d16) break;
            @(negedge clk);
            n++;
         end
         chk("c1_lat",   32'(lat1), 32'd16);
         chk("c1_s",     32'(s1), 32'(es));
         chk("c1_co",    32'(co1), 32'(eco));
         chk("c1_ovf",   32'(ovf1), 32'(eovf));
         chk("c16_lat",  32'(lat16), 32'd1);
         chk("c16_s",    32'(s16), 32'(es));
         chk("c16_co",   32'(co16), 32'(eco));
         chk("c16_ovf",  32'(ovf16), 32'(eovf));

         bus_c1.out_ready = 1'b1;
         bus_c16.out_ready = 1'b1;
         @(negedge clk);
         bus_c1.out_ready = 1'b0;
         bus_c16.out_ready = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
